// File: rtl/feed_pkg.sv
// ============================================================================
//  Module   : feed_pkg
//  Purpose  : Shared types and constants for the pet-feeder feed sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package feed_pkg;

    localparam int BCD_W  = 4;
    localparam int TIME_W = 6 * BCD_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FWD   = 3'd1,
        ST_DEAD1 = 3'd2,
        ST_REV   = 3'd3,
        ST_DEAD2 = 3'd4,
        ST_COOL  = 3'd5
    } feed_state_e;

endpackage

`default_nettype wire

// File: rtl/feed_sequencer_if.sv
// ============================================================================
//  Module   : feed_sequencer_if
//  Purpose  : Time/request inputs and motor/status outputs of the sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface feed_sequencer_if
    import feed_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) ();

    logic              iEN;
    logic [TIME_W-1:0] iCUR_TIME;
    logic [TIME_W-1:0] iMEAL_TIME;
    logic              iFEED;
    logic [CNT_W-1:0]  iFWD_CYCLES;
    logic              oME;
    logic              oMT1;
    logic              oMT2;
    logic              oBUSY;
    logic              oDONE;
    logic [7:0]        oFEED_CNT;

    modport master (
        output iEN, iCUR_TIME, iMEAL_TIME, iFEED, iFWD_CYCLES,
        input  oME, oMT1, oMT2, oBUSY, oDONE, oFEED_CNT
    );

    modport slave (
        input  iEN, iCUR_TIME, iMEAL_TIME, iFEED, iFWD_CYCLES,
        output oME, oMT1, oMT2, oBUSY, oDONE, oFEED_CNT
    );

endinterface

`default_nettype wire

// File: rtl/time_match_edge.sv
// ============================================================================
//  Module   : time_match_edge
//  Purpose  : Registered current/meal time compare with enable; emits one
//             event on the rising edge of the match window.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_match_edge
    import feed_pkg::*;
(
    input  wire              iCLK,
    input  wire              iRST,
    input  wire              iEN,
    input  wire [TIME_W-1:0] iCUR_TIME,
    input  wire [TIME_W-1:0] iMEAL_TIME,
    output logic             oEVENT
);

    logic match_d;
    logic match_q;

    // Raw word compare: malformed BCD simply never matches a valid meal time.
    always_comb begin
        match_d = (iCUR_TIME == iMEAL_TIME) && iEN;
        oEVENT  = match_d && !match_q;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/feed_sequencer.sv
// ============================================================================
//  Module   : feed_sequencer
//  Purpose  : Scheduled/manual feed sequencer driving the H-bridge motor.
//             Optional reverse-unjam stage built when FEED_UNJAM_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module feed_sequencer
    import feed_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 2333333,
    parameter int unsigned REV_CYCLES  = 25000000,
    parameter int unsigned COOL_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 32
) (
    input  wire             iCLK,
    input  wire             iRST,
    feed_sequencer_if.slave bus
);

    // Reload values are duration-1; a zero duration still lasts one cycle.
    localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'((DEAD_CYCLES == 0) ? 0 : DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LD = CNT_W'((COOL_CYCLES == 0) ? 0 : COOL_CYCLES - 1);
`ifdef FEED_UNJAM_EN
    localparam logic [CNT_W-1:0] REV_LD  = CNT_W'((REV_CYCLES == 0) ? 0 : REV_CYCLES - 1);
`endif

    feed_state_e      state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [CNT_W-1:0] fwd_ld;
    logic             pending_d, pending_q;
    logic             feed_d, feed_q;
    logic [7:0]       feed_cnt_d, feed_cnt_q;
    logic             me_d, me_q;
    logic             mt1_d, mt1_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             sched_ev;
    logic             man_ev;
    logic             any_ev;
`ifdef FEED_UNJAM_EN
    logic             mt2_d, mt2_q;
`endif

    time_match_edge u_match (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iEN        (bus.iEN),
        .iCUR_TIME  (bus.iCUR_TIME),
        .iMEAL_TIME (bus.iMEAL_TIME),
        .oEVENT     (sched_ev)
    );

    always_comb begin
        feed_d     = bus.iFEED;
        man_ev     = bus.iFEED && !feed_q;
        any_ev     = sched_ev || man_ev;
        fwd_ld     = (bus.iFWD_CYCLES == '0) ? '0 : bus.iFWD_CYCLES - 1'b1;
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q || any_ev;
        feed_cnt_d = feed_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    pending_d = any_ev;
                    cnt_d     = fwd_ld;
                    state_d   = ST_FWD;
                end
            end
            ST_FWD: begin
                if (cnt_q == '0) begin
                    cnt_d   = DEAD_LD;
                    state_d = ST_DEAD1;
                    if (feed_cnt_q != 8'hFF) begin
                        feed_cnt_d = feed_cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DEAD1: begin
                if (cnt_q == '0) begin
`ifdef FEED_UNJAM_EN
                    cnt_d   = REV_LD;
                    state_d = ST_REV;
`else
                    cnt_d   = COOL_LD;
                    state_d = ST_COOL;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef FEED_UNJAM_EN
            ST_REV: begin
                if (cnt_q == '0) begin
                    cnt_d   = DEAD_LD;
                    state_d = ST_DEAD2;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DEAD2: begin
                if (cnt_q == '0) begin
                    cnt_d   = COOL_LD;
                    state_d = ST_COOL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            ST_COOL: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Outputs decode the next state so they are registered alongside it.
        me_d   = (state_d == ST_FWD) || (state_d == ST_REV);
        mt1_d  = (state_d == ST_FWD);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_COOL) && (state_q != ST_COOL);
`ifdef FEED_UNJAM_EN
        mt2_d  = (state_d == ST_REV);
`endif
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            feed_q     <= 1'b0;
            feed_cnt_q <= 8'd0;
            me_q       <= 1'b0;
            mt1_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef FEED_UNJAM_EN
            mt2_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            feed_q     <= feed_d;
            feed_cnt_q <= feed_cnt_d;
            me_q       <= me_d;
            mt1_q      <= mt1_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef FEED_UNJAM_EN
            mt2_q      <= mt2_d;
`endif
        end
    end

    assign bus.oME       = me_q;
    assign bus.oMT1      = mt1_q;
    assign bus.oBUSY     = busy_q;
    assign bus.oDONE     = done_q;
    assign bus.oFEED_CNT = feed_cnt_q;
`ifdef FEED_UNJAM_EN
    assign bus.oMT2      = mt2_q;
`else
    assign bus.oMT2      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_feed_sequencer.sv
// ============================================================================
//  Module   : tb_feed_sequencer
//  Purpose  : Self-checking bench for feed_sequencer against a timeline model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_feed_sequencer;

    localparam int DEAD = 3;
    localparam int REV  = 5;
    localparam int COOL = 8;
    localparam logic [23:0] MEAL = 24'h123000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Model: m_t = cycles since FWD entry (-1 when idle).
    int   m_t;
    int   m_fwd;
    int   m_cnt;
    bit   m_pend;
    bit   m_mq;
    bit   m_fq;

    feed_sequencer_if #(.CNT_W(32)) bus ();

    feed_sequencer #(
        .DEAD_CYCLES (DEAD),
        .REV_CYCLES  (REV),
        .COOL_CYCLES (COOL),
        .CNT_W       (32)
    ) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cool_start();
`ifdef FEED_UNJAM_EN
        return m_fwd + DEAD + REV + DEAD;
`else
        return m_fwd + DEAD;
`endif
    endfunction

    function automatic logic [12:0] model_out();
        logic me, mt1, mt2, busy, done;
        me = 1'b0; mt1 = 1'b0; mt2 = 1'b0; busy = 1'b0; done = 1'b0;
        if (m_t >= 0) begin
            busy = 1'b1;
            if (m_t < m_fwd) begin
                me = 1'b1; mt1 = 1'b1;
            end
`ifdef FEED_UNJAM_EN
            if (m_t >= m_fwd + DEAD && m_t < m_fwd + DEAD + REV) begin
                me = 1'b1; mt2 = 1'b1;
            end
`endif
            done = (m_t == cool_start());
        end
        return {me, mt1, mt2, busy, done, 8'(m_cnt)};
    endfunction

    task automatic model_step();
        bit match, ev, consume;
        match = (bus.iCUR_TIME == bus.iMEAL_TIME) && bus.iEN;
        ev    = (match && !m_mq) || (bus.iFEED && !m_fq);
        if (rst) begin
            m_t = -1; m_pend = 0; m_mq = 0; m_fq = 0; m_cnt = 0;
        end else begin
            m_mq    = match;
            m_fq    = bus.iFEED;
            consume = (m_t < 0) && m_pend;
            if (m_t >= 0) begin
                m_t++;
                if (m_t == m_fwd && m_cnt < 255) m_cnt++;
                if (m_t >= cool_start() + COOL) m_t = -1;
            end else if (m_pend) begin
                m_t   = 0;
                m_fwd = (bus.iFWD_CYCLES == 0) ? 1 : int'(bus.iFWD_CYCLES);
            end
            m_pend = (m_pend && !consume) || ev;
        end
    endtask

    task automatic cyc(input string tag);
        logic [12:0] got, exp;
        @(posedge clk);
        model_step();
        #1;
        got = {bus.oME, bus.oMT1, bus.oMT2, bus.oBUSY, bus.oDONE, bus.oFEED_CNT};
        exp = model_out();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, got, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    task automatic pulse_feed(input string tag);
        bus.iFEED = 1'b1;
        cyc(tag);
        bus.iFEED = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        m_t = -1; m_fwd = 1; m_cnt = 0; m_pend = 0; m_mq = 0; m_fq = 0;
        rst = 1'b1;
        bus.iEN = 1'b1; bus.iCUR_TIME = 24'h080000; bus.iMEAL_TIME = MEAL;
        bus.iFEED = 1'b0; bus.iFWD_CYCLES = 32'd10;

        run("reset", 3);
        chk("reset_busy", 32'(bus.oBUSY), 0);
        chk("reset_cnt", 32'(bus.oFEED_CNT), 0);
        rst = 1'b0;
        run("idle", 2);

        // Single manual feed, FWD=10
        pulse_feed("manual1");
        run("manual1", 36);
        chk("manual1_cnt", 32'(bus.oFEED_CNT), 1);
        chk("manual1_busy", 32'(bus.oBUSY), 0);

        // Scheduled meal held for 40 cycles: one feed, then none when disabled
        bus.iCUR_TIME = 24'h122959; cyc("sched");
        bus.iCUR_TIME = MEAL;       run("sched_hold", 40);
        bus.iCUR_TIME = 24'h123001; run("sched_after", 10);
        chk("sched_cnt", 32'(bus.oFEED_CNT), 2);
        bus.iEN = 1'b0;
        bus.iCUR_TIME = MEAL;       run("sched_off", 40);
        bus.iCUR_TIME = 24'h123001; run("sched_off", 5);
        chk("sched_off_cnt", 32'(bus.oFEED_CNT), 2);

        // Request during FWD queues a second feed
        pulse_feed("queued");
        run("queued", 4);
        pulse_feed("queued");
        run("queued", 80);
        chk("queued_cnt", 32'(bus.oFEED_CNT), 4);

        // Simultaneous schedule and manual event collapse to one feed
        bus.iEN = 1'b1;
        bus.iCUR_TIME = MEAL; bus.iFEED = 1'b1;
        cyc("simul");
        bus.iFEED = 1'b0;
        run("simul", 45);
        bus.iCUR_TIME = 24'h123001;
        run("simul", 2);
        chk("simul_cnt", 32'(bus.oFEED_CNT), 5);

        // Reset late in the sequence (REV when unjam built)
        pulse_feed("rst_mid");
        run("rst_mid", 15);
        rst = 1'b1;
        cyc("rst_mid");
        chk("rst_me", 32'(bus.oME), 0);
        chk("rst_mt2", 32'(bus.oMT2), 0);
        chk("rst_busy", 32'(bus.oBUSY), 0);
        chk("rst_cnt", 32'(bus.oFEED_CNT), 0);
        rst = 1'b0;
        run("rst_after", 3);

        // Match held across reset yields a fresh event
        bus.iCUR_TIME = MEAL;
        run("hold_rst", 3);
        rst = 1'b1; run("hold_rst", 2);
        rst = 1'b0; run("hold_rst", 40);
        chk("hold_rst_cnt", 32'(bus.oFEED_CNT), 1);
        bus.iCUR_TIME = 24'h123001;
        run("hold_rst", 2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.iFEED       = ($urandom_range(9) == 0);
            bus.iFWD_CYCLES = 32'($urandom_range(12));
            if ($urandom_range(31) == 0) bus.iEN = ~bus.iEN;
            if ($urandom_range(15) == 0)
                bus.iCUR_TIME = ($urandom_range(1) == 0) ? MEAL : 24'($urandom);
            cyc("random");
        end
        bus.iFEED = 1'b0; bus.iEN = 1'b0;
        run("drain", 60);

        // Saturation of the feed counter
        bus.iFWD_CYCLES = 32'd1;
        for (int f = 0; f < 260; f++) begin
            pulse_feed("sat");
            for (int k = 0; k < 60 && (m_t >= 0 || m_pend); k++) cyc("sat");
        end
        chk("sat_cnt", 32'(bus.oFEED_CNT), 255);
        chk("sat_busy", 32'(bus.oBUSY), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
